// File: rtl/iter_multiply_pkg.sv
// Shared execute-unit definitions for the iterative multiplier.
package iter_multiply_pkg;

    typedef enum logic {
        EXECUTE,
        IDLE
    } mul_state_t;

    localparam int unsigned MUL_WIDTH    = 64;
    localparam int unsigned MUL_CNT_INIT = 64;

endpackage

// File: rtl/iter_multiply_twos_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and product sign fixup.
module twos_negate #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic         en,
    output logic [W-1:0] result_c
);

    assign result_c = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/iter_multiply.sv
// Radix-2 shift-add multiplier producing the full 2*WIDTH-bit product, signed or unsigned per operand.
module iter_multiply
    import iter_multiply_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_valid,
    input  logic             x_signed,
    input  logic             y_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             mul_data_ok,
    output logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] mul_hi
);

    localparam int unsigned PW = 2 * WIDTH;

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_p_q, neg_p_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             ok_q, ok_d;

    logic             neg_x_c, neg_y_c;
    logic [WIDTH-1:0] mag_x_c, mag_y_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH:0]   sum_c;

    assign neg_x_c = x_signed & x[WIDTH-1];
    assign neg_y_c = y_signed & y[WIDTH-1];

    twos_negate #(.W(WIDTH)) u_mag_x (.a(x), .en(neg_x_c), .result_c(mag_x_c));
    twos_negate #(.W(WIDTH)) u_mag_y (.a(y), .en(neg_y_c), .result_c(mag_y_c));
    twos_negate #(.W(PW))    u_fix   (.a(acc_q), .en(neg_p_q), .result_c(prod_c));

    // Upper half plus multiplicand when the current multiplier bit is set; carry retained.
    assign sum_c = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : WIDTH'(0))};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_p_d = neg_p_q;
        zero_d  = zero_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ok_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mul_valid) begin
                    state_d = EXECUTE;
                    mcand_d = mag_x_c;
                    acc_d   = {WIDTH'(0), mag_y_c};
                    neg_p_d = neg_x_c ^ neg_y_c;
                    cnt_d   = CNT_W'(WIDTH);
                    zero_d  = (mag_x_c == WIDTH'(0)) || (mag_y_c == WIDTH'(0));
                end
            end
            EXECUTE: begin
                if (zero_q) begin
                    lo_d    = WIDTH'(0);
                    hi_d    = WIDTH'(0);
                    ok_d    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(0)) begin
                    lo_d    = prod_c[WIDTH-1:0];
                    hi_d    = prod_c[PW-1:WIDTH];
                    ok_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_d = {sum_c, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            neg_p_q <= 1'b0;
            zero_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_p_q <= neg_p_d;
            zero_q  <= zero_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ok_q    <= ok_d;
        end
    end

    assign mul_data_ok = ok_q;
    assign mul_lo      = lo_q;
    assign mul_hi      = hi_q;

endmodule

// File: tb/tb_iter_multiply.sv
// Self-checking bench for iter_multiply: directed table, random ops vs. a 128-bit arithmetic model, handshake corners.
module tb_iter_multiply;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_valid;
    logic        x_signed, y_signed;
    logic [63:0] x, y;
    logic        mul_data_ok;
    logic [63:0] mul_lo, mul_hi;

    int n_checks = 0;
    int n_fail   = 0;

    iter_multiply dut (
        .clk        (clk),
        .rst        (rst),
        .mul_valid  (mul_valid),
        .x_signed   (x_signed),
        .y_signed   (y_signed),
        .x          (x),
        .y          (y),
        .mul_data_ok(mul_data_ok),
        .mul_lo     (mul_lo),
        .mul_hi     (mul_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic        xs;
        logic        ys;
        logic [63:0] exp_lo;
        logic [63:0] exp_hi;
    } vec_t;

    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                              input logic as, input logic bs);
        logic signed [127:0] ea, eb, p;
        ea = as ? $signed({{64{a[63]}}, a}) : $signed({64'd0, a});
        eb = bs ? $signed({{64{b[63]}}, b}) : $signed({64'd0, b});
        p  = ea * eb;
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request for one accept edge, then scrambles the operand lines.
    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs);
        x = a; y = b; x_signed = as; y_signed = bs; mul_valid = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        x_signed = 1'($urandom); y_signed = 1'($urandom);
    endtask

    // Edges after the accept edge until data_ok is seen; -1 on timeout. Optionally pulses mul_valid mid-run.
    task automatic wait_done(input int pulse_at, output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (pulse_at > 0 && k == pulse_at) begin
                x = 64'd9; y = 64'd11; mul_valid = 1'b1;
            end else begin
                mul_valid = 1'b0;
            end
            if (mul_data_ok) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic as, input logic bs, input logic [63:0] elo,
                          input logic [63:0] ehi, input int elat);
        int n;
        start(a, b, as, bs);
        wait_done(0, n);
        check({name, " latency"}, 128'(n), 128'(elat));
        check({name, " lo"}, 128'(mul_lo), 128'(elo));
        check({name, " hi"}, 128'(mul_hi), 128'(ehi));
        @(posedge clk);
        #1;
        check({name, " pulse width"}, 128'(mul_data_ok), 128'(0));
    endtask

    initial begin
        vec_t        tbl[6];
        logic [127:0] p;
        logic [63:0] ra, rb;
        logic        ras, rbs;
        int          n, pulses;

        tbl[0] = '{64'd3, 64'd5, 1'b0, 1'b0, 64'd15, 64'd0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                   64'h8000_0000_0000_0000, 64'd0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[4] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                   64'd1, 64'hFFFF_FFFF_FFFF_FFFE};

        rst = 1'b1; mul_valid = 1'b0; x_signed = 1'b0; y_signed = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_ok", 128'(mul_data_ok), 128'(0));
        check("reset lo", 128'(mul_lo), 128'(0));
        check("reset hi", 128'(mul_hi), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i])
            run_op($sformatf("table[%0d]", i), tbl[i].x, tbl[i].y, tbl[i].xs, tbl[i].ys,
                   tbl[i].exp_lo, tbl[i].exp_hi, 65);

        repeat (4) @(posedge clk);
        #1;
        check("hold lo", 128'(mul_lo), 128'(tbl[5].exp_lo));
        check("hold hi", 128'(mul_hi), 128'(tbl[5].exp_hi));

        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            if (i % 7 == 3) ra = 64'h8000_0000_0000_0000;
            if (i % 5 == 2) rb = 64'(32'($urandom_range(0, 255)));
            ras = 1'($urandom); rbs = 1'($urandom);
            p = ref_prod(ra, rb, ras, rbs);
            run_op($sformatf("rand[%0d]", i), ra, rb, ras, rbs, p[63:0], p[127:64],
                   (ra == 64'd0 || rb == 64'd0) ? 1 : 65);
        end

        // Early-out followed by a request issued during the data_ok cycle.
        start(64'd0, 64'h1234, 1'b1, 1'b1);
        wait_done(0, n);
        check("zero latency", 128'(n), 128'(1));
        check("zero lo", 128'(mul_lo), 128'(0));
        check("zero hi", 128'(mul_hi), 128'(0));
        start(64'd6, 64'd7, 1'b0, 1'b0);
        check("b2b pulse width", 128'(mul_data_ok), 128'(0));
        wait_done(0, n);
        check("b2b latency", 128'(n), 128'(65));
        check("b2b lo", 128'(mul_lo), 128'(42));
        check("b2b hi", 128'(mul_hi), 128'(0));

        // Zero multiplier, nonzero multiplicand.
        run_op("zero y", 64'hDEAD_BEEF, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0, 1);

        // mul_valid pulsed during EXECUTE must be ignored.
        @(posedge clk);
        #1;
        p = ref_prod(64'hFFFF_FFFF_FFFF_FFFD, 64'd1000, 1'b1, 1'b1);
        start(64'hFFFF_FFFF_FFFF_FFFD, 64'd1000, 1'b1, 1'b1);
        wait_done(10, n);
        check("midpulse latency", 128'(n), 128'(65));
        check("midpulse lo", 128'(mul_lo), 128'(p[63:0]));
        check("midpulse hi", 128'(mul_hi), 128'(p[127:64]));
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (mul_data_ok) pulses++;
        end
        check("midpulse no extra op", 128'(pulses), 128'(0));

        // Reset partway through an operation.
        run_op("pre-reset", 64'd6, 64'd7, 1'b0, 1'b0, 64'd42, 64'd0, 65);
        start(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset data_ok", 128'(mul_data_ok), 128'(0));
        check("midreset lo", 128'(mul_lo), 128'(0));
        check("midreset hi", 128'(mul_hi), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (mul_data_ok) pulses++;
        end
        check("abandoned op silent", 128'(pulses), 128'(0));
        run_op("post-reset 7*-3", 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFF, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_multiply.md
Name: iter_multiply

Overview:
- Multi-cycle radix-2 shift-add integer multiplier in the execute unit.
- Arithmetic counterpart to the iterative divider; uses the same valid/data_ok handshake so the EX-stage stall logic treats both units identically.
- Produces the full 2*WIDTH-bit product.
- Covers MUL, MULH, MULHSU and MULHU through per-operand signedness flags. Word variants are formed by the caller.

Parameters:
- WIDTH, 64, operand width in bits. The product is 2*WIDTH bits.
- CNT_W, 8, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous active-high reset
- mul_valid  input  1  request strobe; sampled only in IDLE
- x_signed  input  1  treat x as two's complement
- y_signed  input  1  treat y as two's complement
- x  input  WIDTH  multiplicand
- y  input  WIDTH  multiplier
- mul_data_ok  output  1  one-cycle pulse: result valid
- mul_lo  output  WIDTH  product bits [WIDTH-1:0]
- mul_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Reset: state=IDLE; mul_data_ok=0, mul_lo=0, mul_hi=0; counter and accumulator cleared.
- Reset mid-operation: the operation is abandoned, no data_ok pulse is issued, and the next request is accepted normally.
- State machine (2 states, enum in package):
  - IDLE -> EXECUTE on mul_valid.
  - EXECUTE -> IDLE on completion or early-out.
- IDLE, every cycle:
  - mul_data_ok <= 0.
  - mul_lo/mul_hi hold the last result until the next completion.
- Accept edge T0 (IDLE and mul_valid):
  - neg_x = x_signed & x[WIDTH-1]; neg_y = y_signed & y[WIDTH-1].
  - mag_x = neg_x ? (~x+1) : x; mag_y likewise.
  - Most-negative value: magnitude 2^(WIDTH-1), interpreted as unsigned.
  - Latch: multiplicand <= mag_x; acc <= {WIDTH'b0, mag_y}; neg_p <= neg_x ^ neg_y; cnt <= WIDTH; zero_flag <= (mag_x==0)|(mag_y==0).
- EXECUTE, first applicable rule wins:
  - zero_flag: mul_lo <= 0, mul_hi <= 0, mul_data_ok <= 1, go to IDLE. data_ok is high in the cycle after edge T0+1.
  - cnt==0: result = neg_p ? (~acc+1) : acc over the full 2*WIDTH bits; mul_lo <= result[WIDTH-1:0]; mul_hi <= result[2*WIDTH-1:WIDTH]; mul_data_ok <= 1; go to IDLE.
  - Otherwise, one iteration:
    - sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? multiplicand : 0), WIDTH+1 bits, carry kept.
    - acc <= {sum, acc[WIDTH-1:1]}, a logical right shift that carries the sum in.
    - cnt <= cnt-1.
- Latency: a full operation runs WIDTH iteration cycles plus one finish cycle. data_ok is high in the cycle after edge T0+WIDTH+1, i.e. edge T0+65 for the default.
- Handshake rules:
  - mul_valid is ignored in EXECUTE. The requester must hold its operands only on the accept edge.
  - Back-to-back: mul_valid may be high in the cycle where data_ok is high. That cycle is IDLE, so the request is accepted at that edge.
  - x, y and the signed flags are never sampled after the accept edge.
- Signedness combinations:
  - MUL/MULH: x_signed=1, y_signed=1.
  - MULHSU: x_signed=1, y_signed=0.
  - MULHU: x_signed=0, y_signed=0.
  - x_signed=0, y_signed=1 is legal and symmetric.

Decomposition:
- Shared exu package holds:
  - the typedef enum {EXECUTE, IDLE} mul_state_t;
  - constant MUL_WIDTH=64;
  - constant MUL_CNT_INIT=64.
- One combinational sub-module, twos_negate (parameter W), used for operand magnitude and product fixup. Everything else is inline.

Test Plan:
- Unsigned 3*5, flags 0/0 -> mul_lo=15, mul_hi=0; data_ok exactly one cycle, 65 edges after accept.
- Unsigned x=0xFFFF_FFFF_FFFF_FFFF, y=2 -> mul_lo=0xFFFF_FFFF_FFFF_FFFE, mul_hi=1 (carry path).
- Signed x=0x8000_0000_0000_0000, y=0xFFFF_FFFF_FFFF_FFFF -> mul_lo=0x8000_0000_0000_0000, mul_hi=0 (most-negative magnitude).
- MULHSU x=0xFFFF_FFFF_FFFF_FFFF (-1), y=2, flags 1/0 -> mul_lo=0xFFFF_FFFF_FFFF_FFFE, mul_hi=0xFFFF_FFFF_FFFF_FFFF.
- Early-out x=0, y=0x1234, signed -> mul_lo=0, mul_hi=0, data_ok in the cycle after edge T0+1; a second request is accepted on the data_ok cycle and completes correctly.
- Robustness:
  - Pulse mul_valid mid-EXECUTE -> ignored, first result unaffected.
  - Assert rst at iteration 30 -> outputs 0, no data_ok; next request 7*(-3) signed gives mul_lo=0xFFFF_FFFF_FFFF_FFEB, mul_hi=0xFFFF_FFFF_FFFF_FFFF.
